// File: rtl/surf_trig_pkg.sv
// Shared definitions for the SURF trigger link: word layout constants,
// word-build helpers and the transmitter word-sequencing states. The
// TURF-side decoder imports the same package so both ends agree on framing.
package surf_trig_pkg;

  localparam int          TRIG_FLAG_BIT = 15;
  localparam logic [15:0] IDLE_WORD     = 16'h0000;

  typedef enum logic {
    IDLE,
    META
  } trig_state_t;

  // Trigger word: flag bit set, 3 zero bits, 12-bit trigger address.
  function automatic logic [15:0] trig_word(input logic [11:0] addr);
    logic [15:0] w;
    w                = '0;
    w[TRIG_FLAG_BIT] = 1'b1;
    w[11:0]          = addr;
    return w;
  endfunction

  // Metadata word: flag bit clear, metadata in the low byte.
  function automatic logic [15:0] meta_word(input logic [7:0] meta);
    return {8'h00, meta};
  endfunction

endpackage

// File: rtl/surf_trig_tx_fifo.sv
// Synchronous first-word-fall-through FIFO buffering trigger requests.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_push, i_din   : write strobe and data (ignored when full)
//   i_pop           : consume the head entry (ignored when empty)
//   o_dout          : head entry, valid whenever o_empty is low
//   o_full, o_empty : occupancy flags
module surf_trig_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_dout    = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/surf_trig_tx.sv
// SURF trigger link transmitter. Buffers trigger requests and sends each as
// a trigger word followed by a metadata word in consecutive 4-clock slots
// aligned to the 8-clock command cycle.
// Ports:
//   sysclk_i, sysclk_rst_i : clock, synchronous active-high reset
//   sysclk_phase_i         : high on clock 0 of the command cycle
//   train_i                : link training request
//   s_trig_*               : request stream {metadata[7:0], trig_addr[11:0]}
//   trig_dat_o, trig_slot_o: link word and new-word strobe
//   locked_o, phase_err_o  : slot alignment status / off-schedule phase pulse
//   trig_count_o           : triggers fully sent
module surf_trig_tx
  import surf_trig_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] TRAIN_PATTERN = 16'h6A5C,
  parameter string       SYSCLKTYPE    = "NONE"
) (
  input  logic        sysclk_i,
  input  logic        sysclk_rst_i,
  input  logic        sysclk_phase_i,
  input  logic        train_i,
  input  logic [19:0] s_trig_tdata,
  input  logic        s_trig_tvalid,
  output logic        s_trig_tready,
  output logic [15:0] trig_dat_o,
  output logic        trig_slot_o,
  output logic        locked_o,
  output logic        phase_err_o,
  output logic [31:0] trig_count_o
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TRAIN_PATTERN[TRIG_FLAG_BIT] || SYSCLKTYPE == "") begin : g_bad_param
    $error("surf_trig_tx: invalid parameter set");
  end

  logic [1:0]  r_cnt;
  logic        r_locked;
  trig_state_t r_state;
  trig_state_t w_state_nxt;
  logic [7:0]  r_meta;
  logic [7:0]  w_meta_nxt;
  logic [15:0] r_dat;
  logic [15:0] w_dat_nxt;
  logic        r_slot;
  logic        r_phase_err;
  logic [31:0] r_count;
  logic        w_count_inc;
  logic        w_slot_ce;
  logic        w_tready;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [19:0] w_fifo_dout;

  assign w_slot_ce     = sysclk_phase_i || (r_locked && r_cnt == 2'd0);
  assign w_tready      = r_locked && !train_i && !w_full;
  assign s_trig_tready = w_tready;
  assign trig_dat_o    = r_dat;
  assign trig_slot_o   = r_slot;
  assign locked_o      = r_locked;
  assign phase_err_o   = r_phase_err;
  assign trig_count_o  = r_count;

  surf_trig_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(20)
  ) u_fifo (
    .i_clk  (sysclk_i),
    .i_rst  (sysclk_rst_i),
    .i_push (s_trig_tvalid && w_tready),
    .i_din  (s_trig_tdata),
    .i_pop  (w_pop),
    .o_dout (w_fifo_dout),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge sysclk_i) begin
    if (sysclk_rst_i) begin
      r_cnt       <= '0;
      r_locked    <= 1'b0;
      r_state     <= IDLE;
      r_meta      <= '0;
      r_dat       <= IDLE_WORD;
      r_slot      <= 1'b0;
      r_phase_err <= 1'b0;
      r_count     <= '0;
    end else begin
      r_cnt       <= sysclk_phase_i ? 2'd1 : r_cnt + 2'd1;
      r_locked    <= r_locked || sysclk_phase_i;
      r_state     <= w_state_nxt;
      r_meta      <= w_meta_nxt;
      r_dat       <= w_dat_nxt;
      r_slot      <= w_slot_ce;
      r_phase_err <= sysclk_phase_i && r_locked && (r_cnt != 2'd0);
      if (w_count_inc) r_count <= r_count + 32'd1;
    end
  end

  // A phase that resyncs the slot counter is itself a boundary, so a pending
  // META word simply lands in the realigned slot.
  always_comb begin
    w_state_nxt = r_state;
    w_meta_nxt  = r_meta;
    w_dat_nxt   = r_dat;
    w_pop       = 1'b0;
    w_count_inc = 1'b0;
    if (w_slot_ce) begin
      case (r_state)
        IDLE: begin
          if (!w_empty && !train_i) begin
            w_pop       = 1'b1;
            w_dat_nxt   = trig_word(w_fifo_dout[11:0]);
            w_meta_nxt  = w_fifo_dout[19:12];
            w_state_nxt = META;
          end else begin
            w_dat_nxt = train_i ? TRAIN_PATTERN : IDLE_WORD;
          end
        end
        META: begin
          w_dat_nxt   = meta_word(r_meta);
          w_count_inc = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_surf_trig_tx.sv
module tb_surf_trig_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, phase, train, valid;
  logic [19:0] tdata;
  logic        tready;
  logic [15:0] dat;
  logic        slot, locked, perr;
  logic [31:0] cnt;

  always #5 clk = ~clk;

  surf_trig_tx #(
    .FIFO_DEPTH   (DEPTH),
    .TRAIN_PATTERN(16'h6A5C),
    .SYSCLKTYPE   ("NONE")
  ) dut (
    .sysclk_i      (clk),
    .sysclk_rst_i  (rst),
    .sysclk_phase_i(phase),
    .train_i       (train),
    .s_trig_tdata  (tdata),
    .s_trig_tvalid (valid),
    .s_trig_tready (tready),
    .trig_dat_o    (dat),
    .trig_slot_o   (slot),
    .locked_o      (locked),
    .phase_err_o   (perr),
    .trig_count_o  (cnt)
  );

  int unsigned nvec = 0;
  int unsigned nfail = 0;

  // Reference model: queue of buffered requests, one pending metadata byte,
  // and the number of clocks elapsed since the last slot boundary.
  logic [19:0] m_fifo[$];
  bit          m_locked = 0;
  int          m_age = 0;
  bit          m_meta_pend = 0;
  logic [7:0]  m_meta = '0;
  logic [15:0] m_dat = '0;
  bit          m_slot = 0, m_perr = 0;
  logic [31:0] m_count = '0;

  // Stimulus state.
  logic [19:0] req_q[$];
  bit          ph_en = 0;
  int          pcnt = 0;
  bit          started = 0;
  int          perr_seen = 0;
  bit          seen_notready = 0;
  logic [15:0] wlog[$];
  time         tlog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit ph, input bit tr, input bit push,
                            input logic [19:0] d);
    bit          boundary;
    logic [19:0] e;
    if (r) begin
      m_fifo.delete();
      m_locked = 0; m_age = 0; m_meta_pend = 0; m_meta = '0;
      m_dat = '0; m_slot = 0; m_perr = 0; m_count = '0;
      return;
    end
    boundary = ph || (m_locked && m_age == 4);
    m_perr   = ph && m_locked && m_age != 4;
    m_slot   = boundary;
    if (boundary) begin
      if (m_meta_pend) begin
        m_dat = {8'h00, m_meta};
        m_count = m_count + 1;
        m_meta_pend = 0;
      end else if (m_fifo.size() > 0 && !tr) begin
        e = m_fifo.pop_front();
        m_dat = {4'b1000, e[11:0]};
        m_meta = e[19:12];
        m_meta_pend = 1;
      end else begin
        m_dat = tr ? 16'h6A5C : 16'h0000;
      end
    end
    if (push) m_fifo.push_back(d);
    m_age = boundary ? 1 : (m_age < 8 ? m_age + 1 : m_age);
    if (ph) m_locked = 1;
  endtask

  task automatic step(input bit do_rst);
    bit exp_ready, push;
    rst   = do_rst;
    phase = ph_en && (pcnt == 0);
    valid = (req_q.size() > 0);
    tdata = valid ? req_q[0] : 20'($urandom);
    #1;
    exp_ready = m_locked && !train && (m_fifo.size() < DEPTH);
    if (started) check("tready", {31'b0, tready}, {31'b0, exp_ready});
    if (valid && locked === 1'b1 && tready === 1'b0) seen_notready = 1;
    push = valid && exp_ready;
    @(posedge clk);
    model_edge(do_rst, phase, train, push, tdata);
    if (push) void'(req_q.pop_front());
    #1;
    started = 1;
    check("dat",    {16'b0, dat},    {16'b0, m_dat});
    check("slot",   {31'b0, slot},   {31'b0, m_slot});
    check("locked", {31'b0, locked}, {31'b0, m_locked});
    check("perr",   {31'b0, perr},   {31'b0, m_perr});
    check("count",  cnt,             m_count);
    if (perr === 1'b1) perr_seen++;
    if (slot === 1'b1) begin wlog.push_back(dat); tlog.push_back($time); end
    if (ph_en) pcnt = (pcnt + 1) % 8;
  endtask

  task automatic wait_trig();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0);
      if (slot === 1'b1 && dat[15] === 1'b1) found = 1;
    end
    check("wait_trig", {31'b0, found}, 32'd1);
  endtask

  initial begin
    int idx;
    rst = 1; phase = 0; train = 0; valid = 0; tdata = '0;

    // Reset state.
    repeat (3) step(1);

    // Single request {A5,123}.
    ph_en = 1; pcnt = 0;
    repeat (16) step(0);
    wlog.delete(); tlog.delete();
    req_q.push_back({8'hA5, 12'h123});
    repeat (24) step(0);
    check("s1_count", cnt, 32'd1);
    idx = -1;
    foreach (wlog[i]) if (wlog[i] == 16'h8123 && idx < 0) idx = i;
    check("s1_found", {31'b0, (idx >= 1 && idx + 2 < wlog.size())}, 32'd1);
    if (idx >= 1 && idx + 2 < wlog.size()) begin
      check("s1_before", {16'b0, wlog[idx-1]}, 32'h0000);
      check("s1_meta",   {16'b0, wlog[idx+1]}, 32'h00A5);
      check("s1_after",  {16'b0, wlog[idx+2]}, 32'h0000);
      check("s1_spacing", 32'(tlog[idx+1] - tlog[idx]), 32'd40);
    end

    // Five back-to-back requests, FIFO depth 4.
    seen_notready = 0;
    repeat (5) req_q.push_back(20'($urandom));
    repeat (60) step(0);
    check("s2_count", cnt, 32'd6);
    check("s2_backpressure", {31'b0, seen_notready}, 32'd1);

    // Request before the first phase; addr 0 is a valid trigger.
    ph_en = 0;
    repeat (2) step(1);
    req_q.push_back({8'h3C, 12'h000});
    repeat (5) step(0);
    check("s3_stalled", req_q.size(), 32'd1);
    ph_en = 1; pcnt = 0;
    wlog.delete(); tlog.delete();
    repeat (20) step(0);
    check("s3_count", cnt, 32'd1);
    idx = -1;
    foreach (wlog[i]) if (wlog[i] == 16'h8000 && idx < 0) idx = i;
    check("s3_found", {31'b0, (idx >= 0 && idx + 1 < wlog.size())}, 32'd1);
    if (idx >= 0 && idx + 1 < wlog.size()) check("s3_meta", {16'b0, wlog[idx+1]}, 32'h003C);

    // Training raised mid-pair.
    req_q.push_back({8'h11, 12'h456});
    req_q.push_back({8'h77, 12'hABC});
    wait_trig();
    train = 1;
    repeat (24) step(0);
    check("s4_train_word", {16'b0, dat}, 32'h6A5C);
    check("s4_count_train", cnt, 32'd2);
    train = 0;
    repeat (16) step(0);
    check("s4_count", cnt, 32'd3);

    // Phase shifted while a META word is pending.
    req_q.push_back({8'h5A, 12'h789});
    wait_trig();
    step(0);
    perr_seen = 0;
    pcnt = 0;
    repeat (20) step(0);
    check("s5_perr_once", perr_seen, 32'd1);
    check("s5_count", cnt, 32'd4);

    // Reset between trigger and META words.
    req_q.push_back({8'hC3, 12'hFED});
    wait_trig();
    step(1);
    check("s6_dat", {16'b0, dat}, 32'h0000);
    check("s6_locked", {31'b0, locked}, 32'd0);
    check("s6_count", cnt, 32'd0);
    pcnt = 0;
    repeat (20) step(0);
    check("s6_empty_count", cnt, 32'd0);

    // Randomized traffic, training toggles, phase jumps and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && req_q.size() < 3) req_q.push_back(20'($urandom));
      if ($urandom_range(0, 39) == 0) train = ~train;
      if ($urandom_range(0, 149) == 0) pcnt = $urandom_range(0, 7);
      step($urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
